// File: rtl/bs_pkg.sv
// bs_pkg: shared types and constants for the barrel-shifter arbiter slice.
//   bs_state_e : controller states (IDLE / EXEC / RESP)
//   BS_OP_W    : width of the shifter op code
//   BS_OP_*    : op code encoding understood by barrelshifter
//   bs_req_t   : request payload {x, s, op} at the default D_SIZE of 4.
//                Wider instances declare the same layout locally,
//                resized from their own D_SIZE parameter.
package bs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } bs_state_e;

   localparam int BS_OP_W   = 3;
   localparam int BS_D_SIZE = 4;
   localparam int BS_S_W    = $clog2(BS_D_SIZE);

   localparam logic [BS_OP_W-1:0] BS_OP_SLL  = 3'd0; // logical left, vf = ones shifted out
   localparam logic [BS_OP_W-1:0] BS_OP_SRL  = 3'd1; // logical right
   localparam logic [BS_OP_W-1:0] BS_OP_SRA  = 3'd2; // arithmetic right
   localparam logic [BS_OP_W-1:0] BS_OP_ROL  = 3'd3; // rotate left
   localparam logic [BS_OP_W-1:0] BS_OP_ROR  = 3'd4; // rotate right
   localparam logic [BS_OP_W-1:0] BS_OP_SLA  = 3'd5; // arithmetic left, vf = sign lost
   localparam logic [BS_OP_W-1:0] BS_OP_PASS = 3'd6; // y = x
   localparam logic [BS_OP_W-1:0] BS_OP_CLR  = 3'd7; // y = 0

   typedef struct packed {
      logic [BS_D_SIZE-1:0] x;
      logic [BS_S_W-1:0]    s;
      logic [BS_OP_W-1:0]   op;
   } bs_req_t;

endpackage

// File: rtl/barrelshifter.sv
// barrelshifter: combinational shifter shared by all requesters.
//   x      in  D_SIZE          operand
//   s      in  $clog2(D_SIZE)  shift amount
//   op     in  3               op code (see bs_pkg BS_OP_*)
//   y_out  out D_SIZE          result
//   zf_out out 1               result is zero
//   vf_out out 1               overflow (SLL: a one left the word; SLA: sign not preserved)
module barrelshifter
   import bs_pkg::*;
#(
   parameter int D_SIZE = 4
) (
   input  logic [D_SIZE-1:0]         x,
   input  logic [$clog2(D_SIZE)-1:0] s,
   input  logic [BS_OP_W-1:0]        op,
   output logic [D_SIZE-1:0]         y_out,
   output logic                      zf_out,
   output logic                      vf_out
);

   logic [2*D_SIZE-1:0] sll_wide_s;
   logic [D_SIZE-1:0]   sra_s;
   logic [D_SIZE-1:0]   sla_back_s;
   logic [D_SIZE-1:0]   rol_s;
   logic [D_SIZE-1:0]   ror_s;

   // Candidate results for every op, evaluated in parallel.
   always_comb begin
      sll_wide_s = {{D_SIZE{1'b0}}, x} << s;
      sra_s      = $signed(x) >>> s;
      // Shifting the left-shifted value back arithmetically recovers x only
      // when the top s+1 bits of x were all equal, i.e. no signed overflow.
      sla_back_s = $signed(sll_wide_s[D_SIZE-1:0]) >>> s;
      // A shift by D_SIZE yields zero, so s = 0 rotates cleanly.
      rol_s      = (x << s) | (x >> (D_SIZE - int'(s)));
      ror_s      = (x >> s) | (x << (D_SIZE - int'(s)));
   end

   // Op select and flag generation.
   always_comb begin
      y_out  = x;
      vf_out = 1'b0;
      case (op)
         BS_OP_SLL: begin
            y_out  = sll_wide_s[D_SIZE-1:0];
            vf_out = |sll_wide_s[2*D_SIZE-1:D_SIZE];
         end
         BS_OP_SRL:  y_out = x >> s;
         BS_OP_SRA:  y_out = sra_s;
         BS_OP_ROL:  y_out = rol_s;
         BS_OP_ROR:  y_out = ror_s;
         BS_OP_SLA: begin
            y_out  = sll_wide_s[D_SIZE-1:0];
            vf_out = (sla_back_s != x);
         end
         BS_OP_PASS: y_out = x;
         BS_OP_CLR:  y_out = {D_SIZE{1'b0}};
         default:    y_out = x;
      endcase
      zf_out = ~|y_out;
   end

endmodule

// File: rtl/bs_arbiter_rr.sv
// bs_rr_arbiter: combinational round-robin pick.
//   valid    in  N_REQ  request vector
//   rr_ptr   in  ID_W   highest-priority index this round
//   grant    out N_REQ  one-hot winner (all zero when nothing is valid)
//   grant_id out ID_W   winner index (0 when nothing is valid)
module bs_rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

   logic            hi_hit_s;
   logic            lo_hit_s;
   logic [ID_W-1:0] hi_id_s;
   logic [ID_W-1:0] lo_id_s;

   // Lowest valid index at/after rr_ptr, and lowest valid index overall for the wrap.
   always_comb begin
      hi_hit_s = 1'b0;
      lo_hit_s = 1'b0;
      hi_id_s  = {ID_W{1'b0}};
      lo_id_s  = {ID_W{1'b0}};
      // Scanning downwards lets the last hit be the lowest index.
      for (int j = N_REQ - 1; j >= 0; j--) begin
         lo_hit_s = lo_hit_s | valid[j];
         lo_id_s  = valid[j] ? ID_W'(j) : lo_id_s;
         hi_hit_s = hi_hit_s | (valid[j] && (j >= int'(rr_ptr)));
         hi_id_s  = (valid[j] && (j >= int'(rr_ptr))) ? ID_W'(j) : hi_id_s;
      end
   end

   // Winner selection and one-hot encoding.
   always_comb begin
      if (hi_hit_s) begin
         grant_id = hi_id_s;
      end else begin
         grant_id = lo_id_s;
      end
      grant = lo_hit_s ? (ONE_LSB << grant_id) : {N_REQ{1'b0}};
   end

endmodule

// File: rtl/bs_arbiter.sv
// bs_arbiter: shares one barrelshifter among N_REQ requesters, one op at a time.
//   clk_in, rst_n_in              clock, async active-low reset
//   req_valid_in / req_ready_out  request handshake (ready is combinational, IDLE only)
//   req_x_in, req_s_in, req_op_in per-requester operands, sampled on the accept edge
//   rsp_valid_out / rsp_ready_in  response handshake towards the owner
//   rsp_y_out, rsp_zf_out, rsp_vf_out  registered shifter result, held until taken
//   busy_out                      high in EXEC and RESP
//   grant_id_out                  owner of the current transaction
//   done_cnt_out                  completed responses, wrapping
module bs_arbiter
   import bs_pkg::*;
#(
   parameter int D_SIZE = 4,
   parameter int N_REQ  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                                   clk_in,
   input  logic                                   rst_n_in,
   input  logic [N_REQ-1:0]                       req_valid_in,
   output logic [N_REQ-1:0]                       req_ready_out,
   input  logic [N_REQ-1:0][D_SIZE-1:0]           req_x_in,
   input  logic [N_REQ-1:0][$clog2(D_SIZE)-1:0]   req_s_in,
   input  logic [N_REQ-1:0][BS_OP_W-1:0]          req_op_in,
   output logic [N_REQ-1:0]                       rsp_valid_out,
   input  logic [N_REQ-1:0]                       rsp_ready_in,
   output logic [D_SIZE-1:0]                      rsp_y_out,
   output logic                                   rsp_zf_out,
   output logic                                   rsp_vf_out,
   output logic                                   busy_out,
   output logic [$clog2(N_REQ)-1:0]               grant_id_out,
   output logic [CNT_W-1:0]                       done_cnt_out
);

   localparam int S_W  = $clog2(D_SIZE);
   localparam int ID_W = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

   // Same layout as bs_req_t, sized for this instance.
   typedef struct packed {
      logic [D_SIZE-1:0]  x;
      logic [S_W-1:0]     s;
      logic [BS_OP_W-1:0] op;
   } req_t;

   bs_state_e        state_r;
   bs_state_e        state_nxt_s;
   logic [ID_W-1:0]  rr_ptr_r;
   logic [ID_W-1:0]  grant_id_r;
   logic [ID_W-1:0]  win_id_s;
   logic [N_REQ-1:0] win_grant_s;
   logic [N_REQ-1:0] req_ready_s;
   logic [N_REQ-1:0] rsp_valid_r;
   logic [N_REQ-1:0] rsp_valid_nxt_s;
   logic             busy_r;
   logic             busy_nxt_s;
   logic             accept_s;
   logic             capture_s;
   logic             retire_s;
   req_t             req_r;
   logic [D_SIZE-1:0] shf_y_s;
   logic             shf_zf_s;
   logic             shf_vf_s;
   logic [D_SIZE-1:0] rsp_y_r;
   logic             rsp_zf_r;
   logic             rsp_vf_r;
   logic [CNT_W-1:0] done_cnt_r;

   bs_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .valid    (req_valid_in),
      .rr_ptr   (rr_ptr_r),
      .grant    (win_grant_s),
      .grant_id (win_id_s)
   );

   barrelshifter #(
      .D_SIZE (D_SIZE)
   ) u_shifter (
      .x      (req_r.x),
      .s      (req_r.s),
      .op     (req_r.op),
      .y_out  (shf_y_s),
      .zf_out (shf_zf_s),
      .vf_out (shf_vf_s)
   );

   // Next-state logic and per-state strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      retire_s    = 1'b0;
      req_ready_s = {N_REQ{1'b0}};
      case (state_r)
         IDLE: begin
            if (|req_valid_in) begin
               accept_s    = 1'b1;
               req_ready_s = win_grant_s;
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            capture_s   = 1'b1;
            state_nxt_s = RESP;
         end
         RESP: begin
            // Only the owner's ready bit can close the transaction.
            if (rsp_ready_in[grant_id_r]) begin
               retire_s    = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      busy_nxt_s      = (state_nxt_s != IDLE);
      rsp_valid_nxt_s = (state_nxt_s == RESP) ? (ONE_LSB << grant_id_r) : {N_REQ{1'b0}};
   end

   // Control registers: state, round-robin pointer, owner and status flags.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r     <= IDLE;
         rr_ptr_r    <= {ID_W{1'b0}};
         grant_id_r  <= {ID_W{1'b0}};
         busy_r      <= 1'b0;
         rsp_valid_r <= {N_REQ{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         busy_r      <= busy_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         if (accept_s) begin
            grant_id_r <= win_id_s;
            rr_ptr_r   <= (win_id_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : win_id_s + ID_W'(1);
         end
      end
   end

   // Datapath registers: operands on accept, shifter result on EXEC.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         req_r    <= '{x: {D_SIZE{1'b0}}, s: {S_W{1'b0}}, op: {BS_OP_W{1'b0}}};
         rsp_y_r  <= {D_SIZE{1'b0}};
         rsp_zf_r <= 1'b0;
         rsp_vf_r <= 1'b0;
      end else begin
         if (accept_s) begin
            req_r.x  <= req_x_in[win_id_s];
            req_r.s  <= req_s_in[win_id_s];
            req_r.op <= req_op_in[win_id_s];
         end
         if (capture_s) begin
            rsp_y_r  <= shf_y_s;
            rsp_zf_r <= shf_zf_s;
            rsp_vf_r <= shf_vf_s;
         end
      end
   end

   // Completed-response counter, wraps naturally.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         done_cnt_r <= {CNT_W{1'b0}};
      end else if (retire_s) begin
         done_cnt_r <= done_cnt_r + CNT_W'(1);
      end
   end

   assign req_ready_out = req_ready_s;
   assign rsp_valid_out = rsp_valid_r;
   assign rsp_y_out     = rsp_y_r;
   assign rsp_zf_out    = rsp_zf_r;
   assign rsp_vf_out    = rsp_vf_r;
   assign busy_out      = busy_r;
   assign grant_id_out  = grant_id_r;
   assign done_cnt_out  = done_cnt_r;

endmodule
